// File: rtl/mips_abb_pkg.sv
// Shared types for the MIPS pipeline: word/address aliases, memory op codes,
// memory-stage FSM states and small op-decoding helpers.
package mips_abb_pkg;

  typedef logic [31:0] reg_word;
  typedef logic [4:0]  reg_addr;
  typedef logic [31:0] dram_addr;
  typedef logic [31:0] dram_data;
  typedef logic [31:0] instr_addr;
  typedef logic [3:0]  byte_en;

  // Memory operation carried down the pipe with each instruction.
  typedef enum logic [2:0] {
    MEM_NONE    = 3'd0,
    MEM_B_LOAD  = 3'd1,
    MEM_W_LOAD  = 3'd2,
    MEM_B_STORE = 3'd3,
    MEM_W_STORE = 3'd4
  } memop;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  // Width of the REQ+WAIT watchdog counter; must hold TIMEOUT_CYC-1.
  localparam int TIMEOUT_W = 8;

  function automatic logic is_mem(input memop op);
    return op inside {MEM_B_LOAD, MEM_W_LOAD, MEM_B_STORE, MEM_W_STORE};
  endfunction

  function automatic logic is_load(input memop op);
    return op inside {MEM_B_LOAD, MEM_W_LOAD};
  endfunction

  function automatic logic is_word(input memop op);
    return op inside {MEM_W_LOAD, MEM_W_STORE};
  endfunction

endpackage

// File: rtl/stage_mem_if.sv
// Data-memory port: req/gnt request phase, rvalid response phase.
interface stage_mem_if;

  logic                   dm_req;
  logic                   dm_we;
  mips_abb_pkg::byte_en   dm_be;
  mips_abb_pkg::dram_addr dm_addr;
  mips_abb_pkg::dram_data dm_wdata;
  logic                   dm_gnt;
  logic                   dm_rvalid;
  mips_abb_pkg::dram_data dm_rdata;

  // The pipeline stage drives requests; the memory answers.
  modport master (
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );

endinterface

// File: rtl/stage_mem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data on the
// way out, byte extraction with sign extension on the way back.
module mem_lane_align
  import mips_abb_pkg::*;
(
  input  memop     i_memop,
  input  logic [1:0] i_ofs,
  input  dram_data i_memd,
  input  dram_data i_rdata,
  output byte_en   o_be,
  output dram_data o_wdata,
  output reg_word  o_ld_word
);

  logic [7:0] w_byte;

  assign w_byte = i_rdata[{i_ofs, 3'b000} +: 8];

  // Select lanes and load data according to the access size.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    o_be      = '0;
    o_wdata   = '0;
    o_ld_word = i_rdata;
    case (i_memop)
      MEM_W_LOAD, MEM_W_STORE: begin
        o_be      = 4'hF;
        o_wdata   = i_memd;
        o_ld_word = i_rdata;
      end
      MEM_B_LOAD, MEM_B_STORE: begin
        o_be      = byte_en'(4'b0001 << i_ofs);
        o_wdata   = {4{i_memd[7:0]}};
        o_ld_word = {{24{w_byte[7]}}, w_byte};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access stage: ALU results pass through in one cycle; loads and
// stores hold the pipe while a req/gnt/rvalid access completes or times out.
module stage_mem
  import mips_abb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        mem_i_valid,
  input  reg_word     mem_i_res,
  input  logic        mem_i_rfwe,
  input  reg_addr     mem_i_rfwa,
  input  memop        mem_i_memop,
  input  dram_addr    mem_i_mema,
  input  dram_data    mem_i_memd,
  input  instr_addr   mem_i_pc,
  output logic        mem_stall,
  stage_mem_if.master dm,
  output logic        mem_o_valid,
  output logic        mem_o_rfwe,
  output reg_addr     mem_o_rfwa,
  output reg_word     mem_o_wd,
  output instr_addr   mem_o_pc,
  output logic        mem_o_err
);

  mem_state_e r_state, w_next_state;

  // Instruction held for the duration of a memory access.
  reg_word   r_res;
  logic      r_rfwe;
  reg_addr   r_rfwa;
  memop      r_memop;
  dram_addr  r_mema;
  dram_data  r_memd;
  instr_addr r_pc;
  logic      r_err;
  reg_word   r_ld_word;

  logic [TIMEOUT_W-1:0] r_cnt;

  logic      r_o_valid, r_o_rfwe, r_o_err;
  reg_addr   r_o_rfwa;
  reg_word   r_o_wd;
  instr_addr r_o_pc;

  logic     w_accept, w_acc_mem, w_misalign, w_timeout, w_in_req;
  logic     w_capture, w_set_tmo;
  byte_en   w_be;
  dram_data w_wdata;
  reg_word  w_ld_word;

  assign w_accept   = (r_state == IDLE) && mem_i_valid;
  assign w_acc_mem  = w_accept && is_mem(mem_i_memop);
  assign w_misalign = is_word(mem_i_memop) && (mem_i_mema[1:0] != 2'b00);
  assign w_timeout  = (r_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1));
  assign w_in_req   = (r_state == REQ);

  mem_lane_align u_align (
    .i_memop   (r_memop),
    .i_ofs     (r_mema[1:0]),
    .i_memd    (r_memd),
    .i_rdata   (dm.dm_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_ld_word (w_ld_word)
  );

  // State register.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus load-data capture and timeout strobes.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_set_tmo    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc_mem) w_next_state = w_misalign ? DONE : REQ;
      end
      REQ: begin
        if (dm.dm_gnt) begin
          if (!is_load(r_memop)) begin
            w_next_state = DONE;
          end else if (dm.dm_rvalid) begin
            w_capture    = 1'b1;
            w_next_state = DONE;
          end else begin
            w_next_state = WAIT;
          end
        end else if (w_timeout) begin
          w_set_tmo    = 1'b1;
          w_next_state = DONE;
        end
      end
      WAIT: begin
        if (dm.dm_rvalid) begin
          w_capture    = 1'b1;
          w_next_state = DONE;
        end else if (w_timeout) begin
          w_set_tmo    = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Watchdog: REQ is only entered from IDLE, so clearing in IDLE zeroes it on entry.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if (r_state == REQ || r_state == WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Hold registers: latch the instruction on accept, record data or errors later.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      // NOTE: hold registers are reset too, so the bus outputs they feed never carry X.
      r_res     <= '0;
      r_rfwe    <= 1'b0;
      r_rfwa    <= '0;
      r_memop   <= MEM_NONE;
      r_mema    <= '0;
      r_memd    <= '0;
      r_pc      <= '0;
      r_err     <= 1'b0;
      r_ld_word <= '0;
    end else begin
      if (w_acc_mem) begin
        r_res   <= mem_i_res;
        r_rfwe  <= mem_i_rfwe;
        r_rfwa  <= mem_i_rfwa;
        r_memop <= mem_i_memop;
        r_mema  <= mem_i_mema;
        r_memd  <= mem_i_memd;
        r_pc    <= mem_i_pc;
        r_err   <= w_misalign;
      end
      if (w_set_tmo) r_err     <= 1'b1;
      if (w_capture) r_ld_word <= w_ld_word;
    end
  end

  // Writeback register: pass-through on a non-memory accept, held instruction in DONE.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_o_valid <= 1'b0;
      r_o_rfwe  <= 1'b0;
      r_o_rfwa  <= '0;
      r_o_wd    <= '0;
      r_o_pc    <= '0;
      r_o_err   <= 1'b0;
    end else begin
      r_o_valid <= 1'b0;
      if (w_accept && !is_mem(mem_i_memop)) begin
        r_o_valid <= 1'b1;
        r_o_rfwe  <= mem_i_rfwe;
        r_o_rfwa  <= mem_i_rfwa;
        r_o_wd    <= mem_i_res;
        r_o_pc    <= mem_i_pc;
        r_o_err   <= 1'b0;
      end else if (r_state == DONE) begin
        r_o_valid <= 1'b1;
        r_o_rfwe  <= r_rfwe & ~r_err;
        r_o_rfwa  <= r_rfwa;
        r_o_wd    <= (is_load(r_memop) && !r_err) ? r_ld_word : r_res;
        r_o_pc    <= r_pc;
        r_o_err   <= r_err;
      end
    end
  end

  assign mem_stall   = (r_state != IDLE);

  assign dm.dm_req   = w_in_req;
  assign dm.dm_we    = w_in_req && !is_load(r_memop);
  assign dm.dm_be    = w_in_req ? w_be : '0;
  assign dm.dm_addr  = w_in_req ? {r_mema[31:2], 2'b00} : '0;
  assign dm.dm_wdata = w_in_req ? w_wdata : '0;

  assign mem_o_valid = r_o_valid;
  assign mem_o_rfwe  = r_o_rfwe;
  assign mem_o_rfwa  = r_o_rfwa;
  assign mem_o_wd    = r_o_wd;
  assign mem_o_pc    = r_o_pc;
  assign mem_o_err   = r_o_err;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: table-driven pass-through vectors, hand-written memory
// sequences, and a scoreboard queue checked whenever an instruction retires.
module tb_stage_mem;
  import mips_abb_pkg::*;

  localparam int TMO = 255;

  logic      clk;
  logic      rst_n;
  logic      i_valid;
  reg_word   i_res;
  logic      i_rfwe;
  reg_addr   i_rfwa;
  memop      i_memop;
  dram_addr  i_mema;
  dram_data  i_memd;
  instr_addr i_pc;
  logic      o_stall;
  logic      o_valid, o_rfwe, o_err;
  reg_addr   o_rfwa;
  reg_word   o_wd;
  instr_addr o_pc;

  stage_mem_if dm_bus ();

  stage_mem #(.TIMEOUT_CYC(TMO)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .mem_i_valid (i_valid),
    .mem_i_res   (i_res),
    .mem_i_rfwe  (i_rfwe),
    .mem_i_rfwa  (i_rfwa),
    .mem_i_memop (i_memop),
    .mem_i_mema  (i_mema),
    .mem_i_memd  (i_memd),
    .mem_i_pc    (i_pc),
    .mem_stall   (o_stall),
    .dm          (dm_bus),
    .mem_o_valid (o_valid),
    .mem_o_rfwe  (o_rfwe),
    .mem_o_rfwa  (o_rfwa),
    .mem_o_wd    (o_wd),
    .mem_o_pc    (o_pc),
    .mem_o_err   (o_err)
  );

  typedef struct {
    logic      rfwe;
    reg_addr   rfwa;
    reg_word   wd;
    instr_addr pc;
    logic      err;
    logic      chk_wd;
  } exp_t;

  typedef struct {
    logic      valid;
    memop      op;
    reg_word   res;
    logic      rfwe;
    reg_addr   rfwa;
    instr_addr pc;
    reg_word   exp_wd;
    logic      exp_rfwe;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   stall_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Retirement monitor: every mem_o_valid must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_retire: got pc 0x%08h, expected no retire", o_pc);
      end else begin
        e = sb.pop_front();
        check("ret_pc",   o_pc,   e.pc);
        check("ret_rfwe", 32'(o_rfwe), 32'(e.rfwe));
        check("ret_rfwa", 32'(o_rfwa), 32'(e.rfwa));
        check("ret_err",  32'(o_err),  32'(e.err));
        if (e.chk_wd) check("ret_wd", o_wd, e.wd);
      end
    end
  end

  always @(negedge clk) if (o_stall) stall_cnt++;

  task automatic issue(input memop op, input reg_word r, input logic we, input reg_addr wa,
                       input dram_addr a, input dram_data d, input instr_addr p);
    @(posedge clk); #1;
    i_valid = 1'b1; i_memop = op; i_res = r; i_rfwe = we; i_rfwa = wa;
    i_mema = a; i_memd = d; i_pc = p;
    @(posedge clk); #1;
    i_valid = 1'b0; i_memop = MEM_NONE;
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge clk);
    check(name, 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Load with gnt in the first REQ cycle and rvalid in the next.
  task automatic load_seq(input string nm, input memop op, input dram_addr a, input dram_addr exp_addr,
                          input dram_data rd, input reg_word exp_wd, input byte_en exp_be,
                          input instr_addr p);
    int s0;
    sb.push_back('{rfwe: 1'b1, rfwa: 5'd7, wd: exp_wd, pc: p, err: 1'b0, chk_wd: 1'b1});
    s0 = stall_cnt;
    issue(op, 32'h5555_0000, 1'b1, 5'd7, a, 32'h0, p);
    dm_bus.dm_gnt = 1'b1;
    @(negedge clk);
    check({nm, "_req"},  32'(dm_bus.dm_req), 32'd1);
    check({nm, "_we"},   32'(dm_bus.dm_we),  32'd0);
    check({nm, "_be"},   32'(dm_bus.dm_be),  32'(exp_be));
    check({nm, "_addr"}, dm_bus.dm_addr, exp_addr);
    @(posedge clk); #1;
    dm_bus.dm_gnt = 1'b0; dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = rd;
    @(negedge clk);
    check({nm, "_wait_req"}, 32'(dm_bus.dm_req), 32'd0);
    @(posedge clk); #1;
    dm_bus.dm_rvalid = 1'b0; dm_bus.dm_rdata = 32'h0;
    wait_drain({nm, "_drain"}, 10);
    check({nm, "_stall_cycles"}, 32'(stall_cnt - s0), 32'd3);
  endtask

  vec_t vecs[6];

  initial begin
    int s0;

    vecs[0] = '{1'b1, MEM_NONE, 32'h0000_1234, 1'b1, 5'd5,  32'h0040_0000, 32'h0000_1234, 1'b1};
    vecs[1] = '{1'b1, MEM_NONE, 32'h0000_1234, 1'b1, 5'd5,  32'h0040_0004, 32'h0000_1234, 1'b1};
    vecs[2] = '{1'b1, MEM_NONE, 32'h0000_1234, 1'b1, 5'd5,  32'h0040_0008, 32'h0000_1234, 1'b1};
    vecs[3] = '{1'b0, MEM_NONE, 32'hFFFF_FFFF, 1'b1, 5'd9,  32'h0040_000C, 32'h0,         1'b0};
    vecs[4] = '{1'b1, MEM_NONE, 32'hCAFE_F00D, 1'b0, 5'd31, 32'h0040_0010, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b1, MEM_NONE, 32'h8000_0001, 1'b1, 5'd1,  32'h0040_0014, 32'h8000_0001, 1'b1};

    rst_n = 1'b0;
    i_valid = 1'b0; i_memop = MEM_NONE; i_res = '0; i_rfwe = 1'b0; i_rfwa = '0;
    i_mema = '0; i_memd = '0; i_pc = '0;
    dm_bus.dm_gnt = 1'b0; dm_bus.dm_rvalid = 1'b0; dm_bus.dm_rdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_req",   32'(dm_bus.dm_req), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_err",   32'(o_err), 32'd0);
    check("rst_wd",    o_wd, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pass-through table, back to back.
    s0 = stall_cnt;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      i_valid = vecs[i].valid; i_memop = vecs[i].op; i_res = vecs[i].res;
      i_rfwe = vecs[i].rfwe; i_rfwa = vecs[i].rfwa; i_pc = vecs[i].pc;
      if (vecs[i].valid)
        sb.push_back('{rfwe: vecs[i].exp_rfwe, rfwa: vecs[i].rfwa, wd: vecs[i].exp_wd,
                       pc: vecs[i].pc, err: 1'b0, chk_wd: 1'b1});
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    wait_drain("alu_drain", 5);
    check("alu_no_stall", 32'(stall_cnt - s0), 32'd0);

    // Loads.
    load_seq("ldw",    MEM_W_LOAD, 32'h0000_0100, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF, 32'h0040_0100);
    load_seq("ldb3",   MEM_B_LOAD, 32'h0000_0103, 32'h0000_0100, 32'h80FF_0000, 32'hFFFF_FF80, 4'b1000, 32'h0040_0104);
    load_seq("ldb2",   MEM_B_LOAD, 32'h0000_0102, 32'h0000_0100, 32'h80FF_0000, 32'hFFFF_FFFF, 4'b0100, 32'h0040_0108);

    // Byte store with gnt withheld for 4 cycles; inputs offered meanwhile must be ignored.
    sb.push_back('{rfwe: 1'b0, rfwa: 5'd0, wd: 32'h0000_0ABC, pc: 32'h0040_0200, err: 1'b0, chk_wd: 1'b1});
    s0 = stall_cnt;
    issue(MEM_B_STORE, 32'h0000_0ABC, 1'b0, 5'd0, 32'h0000_0101, 32'h0000_00A5, 32'h0040_0200);
    i_valid = 1'b1; i_memop = MEM_NONE; i_res = 32'h0000_0BAD; i_pc = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) dm_bus.dm_gnt = 1'b1;
      @(negedge clk);
      check("stb_req",   32'(dm_bus.dm_req), 32'd1);
      check("stb_we",    32'(dm_bus.dm_we), 32'd1);
      check("stb_be",    32'(dm_bus.dm_be), 32'b0010);
      check("stb_wdata", dm_bus.dm_wdata, 32'hA5A5_A5A5);
      check("stb_addr",  dm_bus.dm_addr, 32'h0000_0100);
      @(posedge clk); #1;
      if (i == 3) i_valid = 1'b0;
    end
    dm_bus.dm_gnt = 1'b0;
    wait_drain("stb_drain", 10);
    check("stb_stall_cycles", 32'(stall_cnt - s0), 32'd6);

    // Misaligned word store: straight to DONE, no request.
    sb.push_back('{rfwe: 1'b0, rfwa: 5'd3, wd: 32'h0, pc: 32'h0040_0300, err: 1'b1, chk_wd: 1'b0});
    s0 = stall_cnt;
    issue(MEM_W_STORE, 32'h0000_0042, 1'b1, 5'd3, 32'h0000_0102, 32'h1122_3344, 32'h0040_0300);
    @(negedge clk);
    check("mis_no_req", 32'(dm_bus.dm_req), 32'd0);
    wait_drain("mis_drain", 10);
    check("mis_stall_cycles", 32'(stall_cnt - s0), 32'd1);

    // Word load granted but never answered: times out after TMO cycles in REQ+WAIT.
    sb.push_back('{rfwe: 1'b0, rfwa: 5'd8, wd: 32'h0, pc: 32'h0040_0400, err: 1'b1, chk_wd: 1'b0});
    s0 = stall_cnt;
    issue(MEM_W_LOAD, 32'h0, 1'b1, 5'd8, 32'h0000_0200, 32'h0, 32'h0040_0400);
    dm_bus.dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_bus.dm_gnt = 1'b0;
    wait_drain("tmo_drain", TMO + 20);
    check("tmo_stall_cycles", 32'(stall_cnt - s0), 32'(TMO + 1));

    // Reset while in WAIT; a late rvalid must not retire anything.
    issue(MEM_W_LOAD, 32'h0, 1'b1, 5'd9, 32'h0000_0300, 32'h0, 32'h0040_0500);
    dm_bus.dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_bus.dm_gnt = 1'b0;
    @(negedge clk);
    check("wait_stall", 32'(o_stall), 32'd1);
    rst_n = 1'b0;
    #2;
    check("rst_wait_stall", 32'(o_stall), 32'd0);
    check("rst_wait_req",   32'(dm_bus.dm_req), 32'd0);
    check("rst_wait_valid", 32'(o_valid), 32'd0);
    check("rst_wait_rfwe",  32'(o_rfwe), 32'd0);
    check("rst_wait_pc",    o_pc, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dm_bus.dm_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(o_valid), 32'd0);
      check("post_rst_stall", 32'(o_stall), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
